ysyx_24100012_alu_arb: RTL and testbench

YSYX_24100012_ALU_ARB -- requirements
Module: ysyx_24100012_alu_arb

---
 rtl/ysyx_24100012_alu_pkg.sv | 17 +
 rtl/ysyx_24100012_rr_arb2.sv | 21 ++
 rtl/ysyx_24100012_alu_arb.sv | 60 ++++++
 tb/tb_ysyx_24100012_alu_arb.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100012_alu_pkg.sv
// ysyx_24100012_alu_pkg: shared FSM state, ALU opcode and csrType constants for the ALU arbiter
package ysyx_24100012_alu_pkg;
  typedef enum logic {S_IDLE, S_RESP} state_t;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [1:0] CSR_PRIV   = 2'b00;
  localparam logic [1:0] CSR_NOPRIV = 2'b11;
  localparam logic [1:0] CSR_IDLE   = 2'b01;
endpackage

// File: rtl/ysyx_24100012_rr_arb2.sv
// ysyx_24100012_rr_arb2: 2-way one-hot arbiter, round-robin or fixed priority under YSYX_24100012_ALU_ARB_FIXED_PRIO_EN
module ysyx_24100012_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
`ifdef YSYX_24100012_ALU_ARB_FIXED_PRIO_EN
  logic unused;
  assign unused = ^{clk, rst, en};
  assign gnt = req[0] ? 2'b01 : {req[1], 1'b0};
`else
  // last starts at 1 so requester 0 wins the first tie
  logic last;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last <= 1'b1;
    else if (en) last <= gnt[1];
  assign gnt = (&req) ? (last ? 2'b01 : 2'b10) : req;
`endif
endmodule

// File: rtl/ysyx_24100012_alu_arb.sv
// ysyx_24100012_alu_arb: two requesters share one combinational ALU; define YSYX_24100012_ALU_ARB_FIXED_PRIO_EN for fixed priority
module ysyx_24100012_alu_arb
  import ysyx_24100012_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_SEL      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  input  logic [2*N_SEL-1:0]      req_sel,
  input  logic [3:0]              req_csr,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [N_SEL-1:0]        alu_sel,
  output logic [1:0]              alu_csr,
  input  logic [DATA_WIDTH-1:0]   alu_res,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    busy
);
  state_t state, state_nxt;
  logic owner, idle, accept;
  logic [1:0] gnt;
  assign idle = state == S_IDLE;
  assign accept = idle & |req_valid;
  // requests are masked outside IDLE so gnt is zero while a result is held
  ysyx_24100012_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (idle ? req_valid : 2'b00),
    .en  (accept),
    .gnt (gnt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      resp_data <= '0;
      owner     <= 1'b0;
    end else if (accept) begin
      resp_data <= alu_res;
      owner     <= gnt[1];
    end
  always_comb state_nxt = idle ? (|req_valid ? S_RESP : S_IDLE) : (resp_ready[owner] ? S_IDLE : S_RESP);
  always_comb begin
    req_ready  = idle ? gnt : 2'b00;
    resp_valid = idle ? 2'b00 : (owner ? 2'b10 : 2'b01);
    busy       = !idle;
    alu_a      = gnt[1] ? req_a[DATA_WIDTH +: DATA_WIDTH] : gnt[0] ? req_a[0 +: DATA_WIDTH] : '0;
    alu_b      = gnt[1] ? req_b[DATA_WIDTH +: DATA_WIDTH] : gnt[0] ? req_b[0 +: DATA_WIDTH] : '0;
    alu_sel    = gnt[1] ? req_sel[N_SEL +: N_SEL] : gnt[0] ? req_sel[0 +: N_SEL] : '0;
    alu_csr    = gnt[1] ? req_csr[3:2] : gnt[0] ? req_csr[1:0] : CSR_IDLE;
  end
endmodule

// File: tb/tb_ysyx_24100012_alu_arb.sv
// tb_ysyx_24100012_alu_arb: scoreboard bench with directed cases and randomized traffic against a rule-level model
module tb_ysyx_24100012_alu_arb;
  localparam int W = 32;
  localparam int S = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [2*W-1:0] req_a = '0, req_b = '0;
  logic [2*S-1:0] req_sel = '0;
  logic [3:0] req_csr = '0;
  logic [W-1:0] alu_a, alu_b, alu_res, resp_data;
  logic [S-1:0] alu_sel;
  logic [1:0] alu_csr;
  logic busy;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  ysyx_24100012_alu_arb #(.DATA_WIDTH(W), .N_SEL(S)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_csr(req_csr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_csr(alu_csr),
    .alu_res(alu_res), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .busy(busy)
  );
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
    case (s)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return {31'b0, $signed(a) < $signed(b)};
      4'b0011: return {31'b0, a < b};
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return '0;
    endcase
  endfunction
  assign alu_res = alu_f(alu_a, alu_b, alu_sel);
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  typedef struct { int g; logic [W-1:0] d; } exp_t;
  exp_t q[$];
  logic [W-1:0] pa[2], pb[2];
  logic [3:0] ps[2];
  logic [1:0] pc[2];
  logic [1:0] vld = '0;
  bit m_busy = 0, m_owner = 0, m_last = 1, acc;
  int last_g;
  // rule-level model of one cycle: who gets granted, what the ALU sees, when the result frees up
  task automatic model();
    int g;
    acc = 0;
    if (!m_busy) begin
      chk("busy_idle", busy, 0);
      if (|vld) begin
`ifdef YSYX_24100012_ALU_ARB_FIXED_PRIO_EN
        g = vld[0] ? 0 : 1;
`else
        g = (vld == 2'b11) ? (m_last ? 0 : 1) : (vld[0] ? 0 : 1);
`endif
        chk("req_ready", req_ready, 2'b01 << g);
        chk("alu_a", alu_a, pa[g]);
        chk("alu_b", alu_b, pb[g]);
        chk("alu_sel", alu_sel, ps[g]);
        chk("alu_csr", alu_csr, pc[g]);
        q.push_back('{g, alu_f(pa[g], pb[g], ps[g])});
        m_last = g[0]; m_owner = g[0]; m_busy = 1; last_g = g; acc = 1;
        vld[g] = 1'b0;
      end else begin
        chk("req_ready_none", req_ready, 0);
        chk("alu_a_none", alu_a, 0);
        chk("alu_csr_none", alu_csr, 2'b01);
      end
    end else begin
      chk("busy_resp", busy, 1);
      chk("req_ready_resp", req_ready, 0);
      chk("alu_a_resp", alu_a, 0);
      chk("alu_csr_resp", alu_csr, 2'b01);
      if (resp_ready[m_owner]) m_busy = 0;
    end
  endtask
  task automatic drive(input logic [1:0] rr);
    @(negedge clk);
    req_valid = vld;
    resp_ready = rr;
    for (int i = 0; i < 2; i++) begin
      req_a[i*W +: W] = pa[i];
      req_b[i*W +: W] = pb[i];
      req_sel[i*S +: S] = ps[i];
      req_csr[i*2 +: 2] = pc[i];
    end
    #1 model();
  endtask
  task automatic setp(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s, input logic [1:0] c);
    pa[i] = a; pb[i] = b; ps[i] = s; pc[i] = c; vld[i] = 1'b1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #3 rst = 1'b0;
    #1 chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    q.delete();
    m_busy = 0; m_last = 1; m_owner = 0; vld = '0; req_valid = '0;
    @(negedge clk);
    #3 rst = 1'b1;
  endtask
  // monitor: pops the scoreboard on every completed response handshake
  always @(negedge clk) begin
    #2;
    if (rst && resp_valid != 2'b00) begin
      chk("resp_onehot", $countones(resp_valid), 1);
      if ((resp_valid & resp_ready) != 2'b00) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got valid=%b with no pending request", resp_valid);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_owner", resp_valid, 2'b01 << e.g);
          chk("resp_data", resp_data, e.d);
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [3:0] ops[10];
    int grants[$];
    ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
    for (int i = 0; i < 2; i++) begin pa[i] = '0; pb[i] = '0; ps[i] = '0; pc[i] = '0; end
    repeat (2) @(negedge clk);
    #1 chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_data", resp_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 0);
    #2 rst = 1'b1;
    // single add from requester 0, one-cycle latency
    setp(0, 5, 3, 4'b0000, 2'b11);
    drive(2'b01);
    chk("add_accept_ready", req_ready, 2'b01);
    drive(2'b01);
    chk("add_resp_valid", resp_valid, 2'b01);
    chk("add_resp_data", resp_data, 8);
    // simultaneous requests right after reset
    do_reset();
    setp(0, 1, 1, 4'b0000, 2'b11);
    setp(1, 9, 4, 4'b1000, 2'b11);
    drive(2'b11);
    chk("tie_first_grant", req_ready, 2'b01);
    drive(2'b11);
    chk("tie_first_data", resp_data, 2);
    drive(2'b11);
    chk("tie_second_grant", req_ready, 2'b10);
    drive(2'b11);
    chk("tie_second_data", resp_data, 5);
    // requester 1 result held while its ready stays low
    setp(1, 32'hF0, 32'h30, 4'b1000, 2'b00);
    drive(2'b00);
    for (int k = 0; k < 10; k++) begin
      drive(2'b01);
      chk("hold_valid", resp_valid, 2'b10);
      chk("hold_data", resp_data, 32'hC0);
      chk("hold_req_ready", req_ready, 0);
    end
    drive(2'b10);
    drive(2'b00);
    // both held valid across six accepts
    do_reset();
    setp(0, 7, 1, 4'b0100, 2'b11);
    setp(1, 6, 2, 4'b0110, 2'b00);
    for (int k = 0; k < 12; k++) begin
      vld = 2'b11;
      drive(2'b11);
      if (acc) grants.push_back(last_g);
    end
    chk("alt_count", grants.size(), 6);
    for (int k = 0; k < grants.size(); k++)
`ifdef YSYX_24100012_ALU_ARB_FIXED_PRIO_EN
      chk("fixed_grant", grants[k], 0);
`else
      chk("rr_grant", grants[k], k % 2);
`endif
    vld = '0;
    drive(2'b11);
    // reset while a result is pending discards it
    setp(1, 3, 3, 4'b0000, 2'b00);
    drive(2'b00);
    drive(2'b00);
    chk("pre_rst_valid", resp_valid, 2'b10);
    do_reset();
    setp(0, 2, 2, 4'b0000, 2'b11);
    setp(1, 4, 4, 4'b0000, 2'b11);
    drive(2'b11);
    chk("post_rst_tie", req_ready, 2'b01);
    drive(2'b11);
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++)
        if (!vld[i] && $urandom_range(0, 2) == 0)
          setp(i, $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
               ops[$urandom_range(0, 9)], 2'($urandom_range(0, 3)));
      drive(2'($urandom_range(0, 3)));
    end
    vld = '0;
    repeat (4) drive(2'b11);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
